iter_shifter: RTL
=================

ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; port names below.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on clock rising edge.
REQ-004 ctrl_shift  input  1  start request, sampled each edge; accepted only in IDLE or DONE.
REQ-005 ctrl_dir  input  1  direction: 0 = SLL (logical left, zero fill), 1 = SRA (arithmetic right, sign fill).
REQ-006 data_operandA  input  32  operand, latched on the accepting edge.
REQ-007 ctrl_shiftamt  input  5  shift amount 0..31, latched on the accepting edge.
REQ-008 data_result  output  32  shifted result; valid when data_resultRDY=1; held until the next accepted start.
REQ-009 data_resultRDY  output  1  one-cycle pulse marking a valid result.
REQ-010 busy  output  1  high while in SHIFT; start requests ignored while high.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT, DONE; reset state IDLE.
REQ-012 IDLE/DONE with ctrl_shift=1: latch operand, amount, dir; clear stage counter to 0; go to SHIFT.
REQ-013 DONE with ctrl_shift=0 SHALL go to IDLE; IDLE with ctrl_shift=0 SHALL stay in IDLE.
REQ-014 SHIFT SHALL run exactly 5 cycles, counter 0..4 selecting stage amounts 16, 8, 4, 2, 1 respectively.
REQ-015 Each SHIFT cycle, if the corresponding amount bit (4..0) is 1, the working register SHALL be replaced by its stage-shifted value; otherwise unchanged.
REQ-016 SRA stage of k SHALL fill the upper k bits with working bit 31; SLL stage of k SHALL fill the lower k bits with 0.
REQ-017 After counter=4, state SHALL go to DONE; data_resultRDY=1 only in DONE.
REQ-018 Latency: RDY SHALL be high in the cycle starting 5 edges after the accepting edge, independent of amount (including 0).
REQ-019 ctrl_shift during SHIFT SHALL be ignored: no relatch, no restart, no effect on result.
REQ-020 Start accepted in DONE SHALL still produce the RDY pulse for the finishing operation in that cycle (back-to-back, no bubble).
REQ-021 Input changes after the accepting edge SHALL NOT affect the in-flight result.
REQ-022 busy SHALL equal (state==SHIFT).
REQ-023 data_result SHALL reflect the working register; intermediate values during SHIFT are don't-care for consumers.

Reset
REQ-024 reset=1 SHALL force state IDLE, counter 0, working/latched registers 0, data_result 0, data_resultRDY 0, busy 0 on that edge.
REQ-025 Reset mid-SHIFT SHALL abort the operation; no RDY pulse for it.
REQ-026 reset SHALL take priority over a simultaneous ctrl_shift.

Structure
REQ-027 A shared package SHALL hold state encodings (IDLE/SHIFT/DONE), direction constants (DIR_SLL=0, DIR_SRA=1), and the stage-amount table (16,8,4,2,1).
REQ-028 One sub-module shift_stage SHALL be used, parameterized by amount k and taking a dir input, pure combinational, 32-bit in/out; the block instantiates five and muxes by counter.
REQ-029 Only the FSM, counter, and latched registers SHALL be sequential; no latches inferred.

Verification
REQ-030 SRA 0x80000000 by 8 -> data_result 0xFF800000 with RDY exactly 5 edges after accept.
REQ-031 SLL 0x00000001 by 31 -> 0x80000000; SRA 0xF0000000 by 31 -> 0xFFFFFFFF; SRA 0x7FFFFFFF by 31 -> 0x00000000.
REQ-032 Amount 0, operand 0x12345678, either dir -> 0x12345678, same 5-cycle latency.
REQ-033 Accept SRA 0x0000FF00 by 4; assert ctrl_shift with new operand on cycles 1-3 -> ignored, result 0x00000FF0, single RDY pulse.
REQ-034 Accept SLL 0x0000000F by 4; reset on 3rd SHIFT cycle -> busy 0, data_result 0, no RDY; following accept SLL 0x1 by 1 -> 0x00000002.
REQ-035 Start held high continuously with new operands accepted in each DONE -> RDY every 6 cycles, each result correct.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
// Shared types and constants for the iterative barrel shifter.
package iter_shifter_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned AMT_W      = 5;
  localparam int unsigned NUM_STAGES = 5;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_SLL = 1'b0;
  localparam logic DIR_SRA = 1'b1;

  // Stage k applied on counter value i; bit (NUM_STAGES-1-i) of the amount enables it.
  localparam int unsigned STAGE_AMT [NUM_STAGES] = '{16, 8, 4, 2, 1};

  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(NUM_STAGES - 1);

endpackage

// File: rtl/iter_shifter_stage.sv
// Fixed-distance shift stage: logical left (zero fill) or arithmetic right (sign fill).
module shift_stage
  import iter_shifter_pkg::*;
#(
  parameter int unsigned K = 1
) (
  input  logic [DATA_W-1:0] din,
  input  logic              dir,
  output logic [DATA_W-1:0] shifted_c
);

  // Select the direction-specific shift of the incoming word.
  always_comb begin
    if (dir == DIR_SRA) begin
      shifted_c = DATA_W'($signed(din) >>> K);
    end else begin
      shifted_c = din << K;
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// Five-cycle iterative shifter: one power-of-two stage per cycle, 16 down to 1.
module iter_shifter
  import iter_shifter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_shift,
  input  logic              ctrl_dir,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [AMT_W-1:0]  ctrl_shiftamt,
  output logic [DATA_W-1:0] data_result,
  output logic              data_resultRDY,
  output logic              busy
);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] work, work_n;
  logic [AMT_W-1:0]  amt, amt_n;
  logic              dir, dir_n;
  logic              rdy_n, busy_n;

  logic [DATA_W-1:0] stage_out [NUM_STAGES];
  logic [DATA_W-1:0] sel_out;
  logic              sel_en;

  // One fixed-distance stage per counter value, all fed by the working register.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    shift_stage #(.K(STAGE_AMT[i])) u_stage (
      .din       (work),
      .dir       (dir),
      .shifted_c (stage_out[i])
    );
  end

  // Pick this cycle's stage result and its enabling amount bit.
  always_comb begin
    sel_out = work;
    sel_en  = 1'b0;
    case (cnt)
      3'd0: begin sel_out = stage_out[0]; sel_en = amt[4]; end
      3'd1: begin sel_out = stage_out[1]; sel_en = amt[3]; end
      3'd2: begin sel_out = stage_out[2]; sel_en = amt[2]; end
      3'd3: begin sel_out = stage_out[3]; sel_en = amt[1]; end
      3'd4: begin sel_out = stage_out[4]; sel_en = amt[0]; end
      default: begin sel_out = work; sel_en = 1'b0; end
    endcase
  end

  // Next-state and next-register logic; DONE accepts a new start without a bubble.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    work_n  = work;
    amt_n   = amt;
    dir_n   = dir;
    case (state)
      IDLE, DONE: begin
        if (ctrl_shift) begin
          state_n = SHIFT;
          cnt_n   = '0;
          work_n  = data_operandA;
          amt_n   = ctrl_shiftamt;
          dir_n   = ctrl_dir;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (sel_en) begin
          work_n = sel_out;
        end
        cnt_n = cnt + CNT_W'(1);
        if (cnt == LAST_STAGE) begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
    rdy_n  = (state_n == DONE);
    busy_n = (state_n == SHIFT);
  end

  // State, datapath and output flags; reset wins over a simultaneous start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      work           <= '0;
      amt            <= '0;
      dir            <= DIR_SLL;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      work           <= work_n;
      amt            <= amt_n;
      dir            <= dir_n;
      data_resultRDY <= rdy_n;
      busy           <= busy_n;
    end
  end

  assign data_result = work;

endmodule
